// File: rtl/pmem_pkg.sv
// rtl/pmem_pkg.sv - shared types and constants for the cacheline pmem responder
package pmem_pkg;

    localparam int PMEM_LINE_BITS = 256;
    localparam int PMEM_ADDR_BITS = 32;
    localparam int OFFSET_BITS    = 5;

    typedef logic [PMEM_LINE_BITS-1:0] line_t;
    typedef logic [PMEM_ADDR_BITS-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/pmem_line_array.sv
// rtl/pmem_line_array.sv - line store: synchronous write, combinational read, no reset
//   clk           : write clock
//   we/widx/wdata : write enable, write line index, write line
//   ridx/rdata    : read line index, read line (combinational)
module pmem_line_array #(
    parameter int WIDTH      = 256,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] widx,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [INDEX_BITS-1:0] ridx,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**INDEX_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency responder for the 256-bit cacheline pmem interface
//   clk, rst_n               : clock, asynchronous active-low reset
//   pmem_read, pmem_write    : held request from the cache until pmem_resp
//   pmem_address, pmem_wdata : byte address (line aligned) and write line
//   pmem_resp, pmem_rdata    : one-cycle completion strobe and read line (zero otherwise)
//   protocol_err             : sticky request-violation flag, cleared only by reset
module pmem_responder
    import pmem_pkg::*;
#(
    parameter int LINE_BITS  = 256,
    parameter int ADDR_BITS  = 32,
    parameter int INDEX_BITS = 6,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [ADDR_BITS-1:0] pmem_address,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic                 pmem_resp,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 protocol_err
);

    localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

    state_t                 state;
    logic [7:0]             cnt;
    logic                   op_write_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [LINE_BITS-1:0]   wdata_q;

    logic [INDEX_BITS-1:0]  req_idx;
    logic [INDEX_BITS-1:0]  idx_q;
    logic [INDEX_BITS-1:0]  rd_idx;
    logic [LINE_BITS-1:0]   rd_line;
    logic                   one_req;
    logic                   both_req;
    logic                   req_mismatch;
    logic                   store_we;

    assign req_idx  = pmem_address[OFFSET_BITS +: INDEX_BITS];
    assign idx_q    = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign one_req  = pmem_read ^ pmem_write;
    assign both_req = pmem_read & pmem_write;

    // Full-address compare: the initiator must hold the exact request, not just the line.
    assign req_mismatch = (pmem_read  != !op_write_q) ||
                          (pmem_write != op_write_q)  ||
                          (pmem_address != addr_q);

    // With LATENCY==1 the read data is captured on the accepting edge, before the
    // latch holds the index, so look up the live address while idle.
    assign rd_idx = (state == IDLE) ? req_idx : idx_q;

    // Write commits at the edge that closes the RESP cycle; reset drops state to
    // IDLE asynchronously, so an aborted write never reaches the store.
    assign store_we = (state == RESP) && op_write_q;

    pmem_line_array #(
        .WIDTH      (LINE_BITS),
        .INDEX_BITS (INDEX_BITS)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (rd_idx),
        .rdata (rd_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pmem_resp    <= 1'b0;
            pmem_rdata   <= '0;
            protocol_err <= 1'b0;
        end else begin
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
            unique case (state)
                IDLE: begin
                    if (both_req) begin
                        protocol_err <= 1'b1;
                    end else if (one_req) begin
                        op_write_q <= pmem_write;
                        addr_q     <= pmem_address;
                        wdata_q    <= pmem_wdata;
                        cnt        <= LAT_LOAD;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            pmem_resp  <= 1'b1;
                            pmem_rdata <= pmem_read ? rd_line : '0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (req_mismatch) begin
                        protocol_err <= 1'b1;
                    end
                    cnt <= cnt - 8'd1;
                    // Moving to RESP as the count steps 1->0 puts resp in the
                    // cycle after edge (accept + LATENCY - 1).
                    if (cnt == 8'd1) begin
                        state      <= RESP;
                        pmem_resp  <= 1'b1;
                        pmem_rdata <= op_write_q ? '0 : rd_line;
                    end
                end
                RESP: begin
                    if (req_mismatch) begin
                        protocol_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - scoreboard bench for pmem_responder with a line-memory reference model
module tb_pmem_responder;
    import pmem_pkg::*;

    localparam int L = 4;

    typedef struct {
        bit    is_read;
        bit    known;
        line_t data;
        int    exp_cyc;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    cyc = 0;

    logic  rd = 1'b0, wr = 1'b0;
    addr_t addr = '0;
    line_t wdata = '0;
    logic  resp, perr;
    line_t rdata;

    logic  rd1 = 1'b0, wr1 = 1'b0;
    addr_t addr1 = '0;
    line_t wdata1 = '0;
    logic  resp1, perr1;
    line_t rdata1;

    int    n_tests = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;
    bit    exp_err = 1'b0;

    exp_t  exp_q[$];
    line_t model_mem [64];
    bit    model_known [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pmem_responder #(.LINE_BITS(256), .ADDR_BITS(32), .INDEX_BITS(6), .LATENCY(L)) u_dut (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd), .pmem_write(wr),
        .pmem_address(addr), .pmem_wdata(wdata), .pmem_resp(resp),
        .pmem_rdata(rdata), .protocol_err(perr)
    );

    pmem_responder #(.LINE_BITS(256), .ADDR_BITS(32), .INDEX_BITS(6), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd1), .pmem_write(wr1),
        .pmem_address(addr1), .pmem_wdata(wdata1), .pmem_resp(resp1),
        .pmem_rdata(rdata1), .protocol_err(perr1)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic line_t rand_line();
        line_t d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Scoreboard monitor: every resp is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (resp) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp=1 expected no response (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_cycle", 256'(cyc), 256'(e.exp_cyc));
                    if (!e.is_read || e.known) check("resp_rdata", rdata, e.data);
                end
            end else begin
                check("rdata_zero_outside_resp", rdata, '0);
                if (exp_q.size() > 0 && cyc > exp_q[0].exp_cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missing_resp: got no resp expected one at cycle %0d (now %0d)",
                             exp_q[0].exp_cyc, cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One held request; optionally the request is dropped two cycles after acceptance.
    task automatic issue(input bit is_read, input addr_t a, input line_t d, input bit drop_mid);
        exp_t e;
        int   idx;
        @(posedge clk); #1;
        idx       = int'(a[OFFSET_BITS +: 6]);
        e.is_read = is_read;
        e.known   = is_read && model_known[idx];
        e.data    = is_read ? model_mem[idx] : '0;
        e.exp_cyc = cyc + L;
        exp_q.push_back(e);
        rd = is_read; wr = !is_read; addr = a; wdata = d;
        if (drop_mid) begin
            repeat (2) @(posedge clk);
            #1;
            rd = 1'b0; wr = 1'b0;
            exp_err = 1'b1;
            repeat (L - 1) @(posedge clk);
        end else begin
            repeat (L + 1) @(posedge clk);
        end
        #1;
        rd = 1'b0; wr = 1'b0;
        if (!is_read) begin
            model_mem[idx]   = d;
            model_known[idx] = 1'b1;
        end
    endtask

    task automatic lat1_txn(input bit is_read, input addr_t a, input line_t d, input line_t exp);
        @(posedge clk); #1;
        rd1 = is_read; wr1 = !is_read; addr1 = a; wdata1 = d;
        @(negedge clk);
        check("lat1_no_resp_before_accept", 256'(resp1), 256'(0));
        @(negedge clk);
        check("lat1_resp_next_cycle", 256'(resp1), 256'(1));
        check("lat1_rdata", rdata1, exp);
        @(posedge clk); #1;
        rd1 = 1'b0; wr1 = 1'b0;
        @(negedge clk);
        check("lat1_resp_one_cycle", 256'(resp1), 256'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        line_t d1, d2, beef;
        addr_t a;
        bit    is_rd;

        for (int i = 0; i < 64; i++) model_known[i] = 1'b0;
        beef = {8{32'hDEADBEEF}};

        repeat (3) @(negedge clk);
        check("reset_resp", 256'(resp), 256'(0));
        check("reset_rdata", rdata, '0);
        check("reset_protocol_err", 256'(perr), 256'(0));
        rst_n  = 1'b1;
        mon_en = 1'b1;

        issue(1'b0, 32'h0000_0040, beef, 1'b0);
        check("write_no_err", 256'(perr), 256'(exp_err));
        issue(1'b1, 32'h0000_0040, '0, 1'b0);

        d1 = rand_line();
        issue(1'b0, 32'h0000_0060, d1, 1'b0);
        issue(1'b1, 32'h0000_0860, '0, 1'b0);
        issue(1'b1, 32'h0000_007F, '0, 1'b0);
        check("alias_no_err", 256'(perr), 256'(exp_err));

        // Read and write together while idle: nothing accepted, error sticks.
        @(posedge clk); #1;
        rd = 1'b1; wr = 1'b1; addr = 32'h0000_0040;
        repeat (3) @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
        exp_err = 1'b1;
        check("both_req_err", 256'(perr), 256'(exp_err));
        issue(1'b1, 32'h0000_0040, '0, 1'b0);
        check("err_sticky", 256'(perr), 256'(exp_err));

        issue(1'b1, 32'h0000_0060, '0, 1'b1);
        check("drop_err", 256'(perr), 256'(exp_err));

        // Reset during WAIT aborts the write; the line keeps its old contents.
        d2 = rand_line();
        @(posedge clk); #1;
        wr = 1'b1; addr = 32'h0000_0060; wdata = d2;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_err = 1'b0;
        check("abort_resp", 256'(resp), 256'(0));
        check("abort_err_cleared", 256'(perr), 256'(exp_err));
        wr = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (L + 2) @(posedge clk);
        issue(1'b1, 32'h0000_0060, '0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            a = $urandom();
            a[10:5] = 6'($urandom_range(0, 7));
            is_rd = $urandom_range(0, 1) == 1;
            issue(is_rd, a, rand_line(), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        check("random_no_err", 256'(perr), 256'(exp_err));

        d1 = rand_line();
        lat1_txn(1'b0, 32'h0000_1120, d1, '0);
        lat1_txn(1'b1, 32'h0000_0120, '0, d1);
        check("lat1_no_err", 256'(perr1), 256'(0));

        repeat (L + 3) @(posedge clk);
        check("all_resp_seen", 256'(exp_q.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Synthesizable responder for the 256-bit cacheline physical-memory interface; mp3 (cache side) is the initiator.
- Accepts one line read or write at a time and returns a single-cycle resp after a fixed, programmable latency.
- Backs the transaction with a small on-chip line store.
- Replaces the behavioural memory in FPGA builds; also serves as a protocol checker in simulation.

Parameters:
- LINE_BITS, 256, cacheline width in bits.
- ADDR_BITS, 32, byte-address width.
- INDEX_BITS, 6, log2 of the number of stored lines (64 lines).
- LATENCY, 4, clock edges from request acceptance to resp; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- pmem_read  input  1  line read request; held high until resp.
- pmem_write  input  1  line write request; held high until resp.
- pmem_address  input  ADDR_BITS  byte address; bits [4:0] ignored (line aligned).
- pmem_wdata  input  LINE_BITS  write line data.
- pmem_resp  output  1  one-cycle completion strobe.
- pmem_rdata  output  LINE_BITS  read line data; valid only while pmem_resp is high.
- protocol_err  output  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: pmem_resp=0, pmem_rdata=0, protocol_err=0, FSM=IDLE, latency counter=0. Line store contents are not reset; reading an unwritten line returns an undefined value.
- Reset mid-transaction: aborts the transaction immediately. No resp is issued. A pending write is not committed.
- State IDLE:
  - At a clock edge with exactly one of pmem_read/pmem_write high, latch op, index = pmem_address[5 +: INDEX_BITS], and wdata.
  - Load counter with LATENCY-1. Go to WAIT, or go directly to RESP if LATENCY==1.
  - Both read and write high: set protocol_err, accept nothing, stay IDLE.
- State WAIT:
  - Decrement the counter each edge. When the counter reaches 0, go to RESP.
- Request checking during WAIT/RESP:
  - The request must remain asserted with the same op and address throughout WAIT and RESP.
  - Any drop or change sets protocol_err. The latched request still completes normally.
- State RESP (exactly one cycle):
  - pmem_resp=1.
  - Read: pmem_rdata = store[latched index].
  - Write: the store is updated at the closing edge of this cycle; pmem_rdata stays 0.
  - Next state is IDLE.
- Timing: a request accepted at edge k has pmem_resp high in the cycle following edge k+LATENCY-1. Total latency is LATENCY cycles from acceptance, plus one cycle of IDLE sampling.
- Back-to-back requests: the cycle after RESP is IDLE and samples a new request. Minimum request spacing is LATENCY+1 cycles.
- Outside RESP: pmem_rdata is driven to 0 (not held), so the bench can detect stale-data use.
- Addressing: upper address bits above INDEX_BITS+5 are ignored; addresses alias modulo 2^(INDEX_BITS+5) bytes. Bits [4:0] never affect indexing.
- Read-after-write to the same line in consecutive transactions returns the newly written data.
- protocol_err is cleared only by reset.
- The line store is a synchronous-write, combinational-read array indexed by the latched index.

Decomposition:
- pmem_pkg: line_t (logic [LINE_BITS-1:0]), addr_t, the state enum {IDLE, WAIT, RESP}, and the constant OFFSET_BITS=5.
- Sub-module pmem_line_array: parameterized storage with write enable, write index and data, and read index. Synchronous write, async read; no reset.
- pmem_responder holds the FSM, counter, request latch and checker.

Test Plan:
- Reset, then write line 0xDEADBEEF repeated to address 0x0000_0040 with LATENCY=4 -> pmem_resp high exactly one cycle, 4 cycles after acceptance; protocol_err=0.
- Read 0x0000_0040 -> pmem_resp after 4 cycles with pmem_rdata=0xDEADBEEF repeated; pmem_rdata=0 on the cycles before and after.
- Write 0x0000_0060 then read 0x0000_0860 (aliases with INDEX_BITS=6) -> the read returns the written data. Read 0x0000_007F returns the same line.
- Assert pmem_read and pmem_write together in IDLE -> no resp, protocol_err=1 and sticky; after releasing both, a valid read still completes.
- Drop pmem_read two cycles into WAIT -> resp is still issued at the nominal cycle and protocol_err=1.
- Start a write, pulse rst_n low during WAIT -> pmem_resp never asserts; a later read of that line does not return the aborted wdata. LATENCY=1 build: resp in the cycle right after acceptance.
